// File: rtl/ahbl_arbiter_2m.sv
// Two-master AHB-Lite arbiter: each master's address phase is captured into a
// one-entry buffer and replayed on the shared bus as a single NONSEQ transfer.
module ahbl_arbiter_2m #(
   parameter int ARB_MODE = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic [2:0]  M0_HSIZE,
   input  logic        M0_HWRITE,
   input  logic [31:0] M0_HWDATA,
   output logic        M0_HREADY,
   output logic [31:0] M0_HRDATA,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic [2:0]  M1_HSIZE,
   input  logic        M1_HWRITE,
   input  logic [31:0] M1_HWDATA,
   output logic        M1_HREADY,
   output logic [31:0] M1_HRDATA,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   output logic [1:0]  BUS_OWNER
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      DATA = 2'd2
   } mst_state_e;

   mst_state_e  state     [2];
   logic [31:0] buf_addr  [2];
   logic [2:0]  buf_size  [2];
   logic        buf_write [2];
   logic        dp_valid;
   logic        dp_owner;
   logic        last_grant;

   logic [31:0] m_haddr  [2];
   logic [1:0]  m_htrans [2];
   logic [2:0]  m_hsize  [2];
   logic        m_hwrite [2];
   logic [1:0]  m_hready;
   logic [1:0]  capture;
   logic [1:0]  pend;
   logic        issue;
   logic        winner;

   // Only HTRANS[1] matters: IDLE and BUSY look the same to the arbiter.
   logic unused_htrans;
   assign unused_htrans = ^{M0_HTRANS[0], M1_HTRANS[0]};

   assign m_haddr[0]  = M0_HADDR;
   assign m_haddr[1]  = M1_HADDR;
   assign m_htrans[0] = M0_HTRANS;
   assign m_htrans[1] = M1_HTRANS;
   assign m_hsize[0]  = M0_HSIZE;
   assign m_hsize[1]  = M1_HSIZE;
   assign m_hwrite[0] = M0_HWRITE;
   assign m_hwrite[1] = M1_HWRITE;

   // A master's new address phase is taken exactly when it sees its HREADY high.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // NOTE: every variable written here gets a default first, so no path infers a latch.
         m_hready[i] = 1'b1;
         pend[i]     = 1'b0;
         if (state[i] == PEND) begin
            m_hready[i] = 1'b0;
            pend[i]     = 1'b1;
         end else if (state[i] == DATA) begin
            m_hready[i] = HREADY;
         end
         capture[i] = m_htrans[i][1] & m_hready[i];
      end
   end

   always_comb begin
      issue = HREADY && (pend != 2'b00);
      if (pend == 2'b11)
         winner = (ARB_MODE == 1) ? 1'b0 : ~last_grant;
      else
         winner = pend[1];
   end

   always_comb begin
      HTRANS = 2'b00;
      HADDR  = '0;
      HSIZE  = '0;
      HWRITE = 1'b0;
      if (issue) begin
         HTRANS = 2'b10;
         HADDR  = buf_addr[winner];
         HSIZE  = buf_size[winner];
         HWRITE = buf_write[winner];
      end
   end

   assign HWDATA    = dp_valid ? (dp_owner ? M1_HWDATA : M0_HWDATA) : '0;
   assign BUS_OWNER = {dp_owner, dp_valid};
   assign M0_HREADY = m_hready[0];
   assign M1_HREADY = m_hready[1];
   assign M0_HRDATA = HRDATA;
   assign M1_HRDATA = HRDATA;

   // NOTE: non-blocking assignments, so every register updates from pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int i = 0; i < 2; i++) begin
            state[i]     <= IDLE;
            // NOTE: the capture buffers are cleared on reset as well, so their contents are defined from the first cycle.
            buf_addr[i]  <= '0;
            buf_size[i]  <= '0;
            buf_write[i] <= 1'b0;
         end
         dp_valid   <= 1'b0;
         dp_owner   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (state[i])
               IDLE:    if (capture[i]) state[i] <= PEND;
               PEND:    if (issue && (winner == 1'(i))) state[i] <= DATA;
               DATA:    if (HREADY) state[i] <= capture[i] ? PEND : IDLE;
               default: state[i] <= IDLE;
            endcase
            if (capture[i]) begin
               buf_addr[i]  <= m_haddr[i];
               buf_size[i]  <= m_hsize[i];
               buf_write[i] <= m_hwrite[i];
            end
         end
         // Data-phase ownership moves only on a ready cycle.
         if (issue) begin
            last_grant <= winner;
            dp_valid   <= 1'b1;
            dp_owner   <= winner;
         end else if (HREADY) begin
            dp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// Bench for ahbl_arbiter_2m: directed scenarios plus random traffic, with every
// cycle compared against a transaction-queue model of the arbitration rules.
module tb_ahbl_arbiter_2m;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        hreset;
   logic        hready;
   logic [31:0] hrdata;
   logic [31:0] m_haddr  [2];
   logic [1:0]  m_htrans [2];
   logic [2:0]  m_hsize  [2];
   logic        m_hwrite [2];
   logic [31:0] m_hwdata [2];

   // Outputs of the two instances, index = ARB_MODE
   logic [31:0] haddr_d  [2];
   logic [1:0]  htrans_d [2];
   logic [2:0]  hsize_d  [2];
   logic        hwrite_d [2];
   logic [31:0] hwdata_d [2];
   logic [1:0]  owner_d  [2];
   logic        m0_rdy_d [2];
   logic        m1_rdy_d [2];
   logic [31:0] m0_rd_d  [2];
   logic [31:0] m1_rd_d  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ahbl_arbiter_2m #(.ARB_MODE(g)) dut (
         .HCLK      (clk),
         .HRESET    (hreset),
         .M0_HADDR  (m_haddr[0]),
         .M0_HTRANS (m_htrans[0]),
         .M0_HSIZE  (m_hsize[0]),
         .M0_HWRITE (m_hwrite[0]),
         .M0_HWDATA (m_hwdata[0]),
         .M0_HREADY (m0_rdy_d[g]),
         .M0_HRDATA (m0_rd_d[g]),
         .M1_HADDR  (m_haddr[1]),
         .M1_HTRANS (m_htrans[1]),
         .M1_HSIZE  (m_hsize[1]),
         .M1_HWRITE (m_hwrite[1]),
         .M1_HWDATA (m_hwdata[1]),
         .M1_HREADY (m1_rdy_d[g]),
         .M1_HRDATA (m1_rd_d[g]),
         .HADDR     (haddr_d[g]),
         .HTRANS    (htrans_d[g]),
         .HSIZE     (hsize_d[g]),
         .HWRITE    (hwrite_d[g]),
         .HWDATA    (hwdata_d[g]),
         .HREADY    (hready),
         .HRDATA    (hrdata),
         .BUS_OWNER (owner_d[g])
      );
   end

   int checks   = 0;
   int failures = 0;
   int mode     = 0;

   // Reference model: accepted-but-unissued requests in arrival order, plus one data-phase slot.
   typedef struct packed {
      logic        m;
      logic [31:0] addr;
      logic [2:0]  size;
      logic        write;
   } req_t;

   req_t wait_q[$];
   bit   dp_busy     = 1'b0;
   logic owner_idx   = 1'b0;
   logic last_served = 1'b1;

   bit [1:0]    has;
   logic        exp_issue;
   logic        pick;
   int          pick_idx;
   logic [1:0]  exp_rdy = 2'b11;

   logic [31:0] obs_haddr, obs_hwdata;
   logic [1:0]  obs_htrans, obs_owner;
   logic        obs_m0_rdy, obs_m1_rdy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   task automatic sample_and_check();
      logic [31:0] e_addr, e_wdata;
      logic [2:0]  e_size;
      logic        e_write;
      has = '0;
      foreach (wait_q[i]) has[wait_q[i].m] = 1'b1;
      exp_issue = hready && (has != 2'b00);
      if (has == 2'b11) pick = (mode == 1) ? 1'b0 : ~last_served;
      else              pick = has[1];
      pick_idx = -1;
      foreach (wait_q[i]) if (wait_q[i].m == pick) pick_idx = i;
      for (int m = 0; m < 2; m++)
         exp_rdy[m] = has[m] ? 1'b0 : ((dp_busy && owner_idx == 1'(m)) ? hready : 1'b1);
      e_addr = '0; e_size = '0; e_write = 1'b0;
      if (exp_issue && pick_idx >= 0) begin
         e_addr  = wait_q[pick_idx].addr;
         e_size  = wait_q[pick_idx].size;
         e_write = wait_q[pick_idx].write;
      end
      e_wdata = dp_busy ? m_hwdata[owner_idx] : 32'h0;

      obs_haddr  = haddr_d[mode];
      obs_htrans = htrans_d[mode];
      obs_hwdata = hwdata_d[mode];
      obs_owner  = owner_d[mode];
      obs_m0_rdy = m0_rdy_d[mode];
      obs_m1_rdy = m1_rdy_d[mode];

      check("htrans",    32'(obs_htrans), exp_issue ? 32'h2 : 32'h0);
      check("haddr",     obs_haddr, e_addr);
      check("hsize",     32'(hsize_d[mode]), 32'(e_size));
      check("hwrite",    32'(hwrite_d[mode]), 32'(e_write));
      check("hwdata",    obs_hwdata, e_wdata);
      check("bus_owner", 32'(obs_owner), 32'({owner_idx, dp_busy}));
      check("m0_hready", 32'(obs_m0_rdy), 32'(exp_rdy[0]));
      check("m1_hready", 32'(obs_m1_rdy), 32'(exp_rdy[1]));
      check("m0_hrdata", m0_rd_d[mode], hrdata);
      check("m1_hrdata", m1_rd_d[mode], hrdata);
   endtask

   task automatic model_update();
      logic [1:0] acc;
      if (hreset) begin
         wait_q.delete();
         dp_busy     = 1'b0;
         owner_idx   = 1'b0;
         last_served = 1'b1;
         exp_rdy     = 2'b11;
         return;
      end
      for (int m = 0; m < 2; m++) acc[m] = m_htrans[m][1] && exp_rdy[m];
      if (exp_issue && pick_idx >= 0) begin
         wait_q.delete(pick_idx);
         dp_busy     = 1'b1;
         owner_idx   = pick;
         last_served = pick;
      end else if (hready) begin
         dp_busy = 1'b0;
      end
      for (int m = 0; m < 2; m++)
         if (acc[m])
            wait_q.push_back(req_t'{m: 1'(m), addr: m_haddr[m], size: m_hsize[m], write: m_hwrite[m]});
   endtask

   // One bus cycle: compare mid-cycle, advance the model at the edge, drive new inputs just after.
   task automatic step();
      @(negedge clk);
      sample_and_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_m(input int m, input logic [1:0] tr, input logic [31:0] a,
                        input logic w, input logic [31:0] d);
      m_htrans[m] = tr;
      m_haddr[m]  = a;
      m_hsize[m]  = 3'd2;
      m_hwrite[m] = w;
      m_hwdata[m] = d;
   endtask

   task automatic idle_both();
      set_m(0, T_IDLE, 32'h0, 1'b0, 32'h0);
      set_m(1, T_IDLE, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      idle_both();
      hready = 1'b1;
      hreset = 1'b1;
      step();
      hreset = 1'b0;
   endtask

   // Masters change their address phase only after they saw HREADY high.
   task automatic drive_random(input int req_pct, input int rdy_pct);
      for (int m = 0; m < 2; m++) begin
         if (exp_rdy[m]) begin
            if ($urandom_range(99) < req_pct) m_htrans[m] = $urandom_range(1) ? T_NONSEQ : T_SEQ;
            else                              m_htrans[m] = $urandom_range(1) ? T_IDLE : T_BUSY;
            m_haddr[m]  = {3'b000, 1'(m), 28'($urandom)};
            m_hsize[m]  = 3'($urandom_range(2));
            m_hwrite[m] = 1'($urandom_range(1));
            m_hwdata[m] = $urandom;
         end
      end
      hready = ($urandom_range(99) < rdy_pct);
      hrdata = $urandom;
   endtask

   initial begin
      hrdata = 32'h0;
      hready = 1'b1;
      hreset = 1'b1;
      set_m(0, T_NONSEQ, 32'h55, 1'b1, 32'h0);
      set_m(1, T_NONSEQ, 32'h66, 1'b0, 32'h0);
      @(posedge clk);
      #1;

      // Reset held with both masters requesting, then the cycle after release.
      step();
      check("t1_rst_htrans", 32'(obs_htrans), 32'h0);
      check("t1_rst_haddr",  obs_haddr, 32'h0);
      check("t1_rst_rdy",    32'({obs_m1_rdy, obs_m0_rdy}), 32'h3);
      check("t1_rst_owner",  32'(obs_owner), 32'h0);
      hreset = 1'b0;
      step();
      check("t1_post_htrans", 32'(obs_htrans), 32'h0);
      check("t1_post_rdy",    32'({obs_m1_rdy, obs_m0_rdy}), 32'h3);
      check("t1_post_owner",  32'(obs_owner), 32'h0);

      // Single M0 write, zero-wait slave.
      do_reset();
      set_m(0, T_NONSEQ, 32'h10, 1'b1, 32'h0);
      step();
      set_m(0, T_IDLE, 32'h0, 1'b0, 32'hDEADBEEF);
      step();
      check("t2_htrans", 32'(obs_htrans), 32'h2);
      check("t2_haddr",  obs_haddr, 32'h10);
      check("t2_m0_low", 32'(obs_m0_rdy), 32'h0);
      step();
      check("t2_hwdata", obs_hwdata, 32'hDEADBEEF);
      check("t2_owner",  32'(obs_owner), 32'h1);
      check("t2_m0_up",  32'(obs_m0_rdy), 32'h1);

      // Round-robin: simultaneous reads, then again after an M0-only transfer.
      do_reset();
      set_m(0, T_NONSEQ, 32'h100, 1'b0, 32'h0);
      set_m(1, T_NONSEQ, 32'h200, 1'b0, 32'h0);
      step();
      idle_both();
      step();
      check("t3_first",  obs_haddr, 32'h100);
      step();
      check("t3_second", obs_haddr, 32'h200);
      check("t3_second_trans", 32'(obs_htrans), 32'h2);
      step();
      check("t3_m1_owner", 32'(obs_owner), 32'h3);
      set_m(0, T_NONSEQ, 32'h180, 1'b0, 32'h0);
      step();
      idle_both();
      step();
      check("t3_solo", obs_haddr, 32'h180);
      step();
      set_m(0, T_NONSEQ, 32'h100, 1'b0, 32'h0);
      set_m(1, T_NONSEQ, 32'h200, 1'b0, 32'h0);
      step();
      idle_both();
      step();
      check("t3_rep_first",  obs_haddr, 32'h200);
      step();
      check("t3_rep_second", obs_haddr, 32'h100);
      step();

      // M1 write data phase stretched by three wait states while M0 is pending.
      do_reset();
      set_m(1, T_NONSEQ, 32'h300, 1'b1, 32'h0);
      step();
      set_m(1, T_IDLE, 32'h0, 1'b0, 32'hCAFE0001);
      set_m(0, T_NONSEQ, 32'h400, 1'b0, 32'h0);
      step();
      check("t4_m1_issue", obs_haddr, 32'h300);
      set_m(0, T_IDLE, 32'h0, 1'b0, 32'h0);
      hready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t4_wait_htrans", 32'(obs_htrans), 32'h0);
         check("t4_wait_hwdata", obs_hwdata, 32'hCAFE0001);
         check("t4_wait_owner",  32'(obs_owner), 32'h3);
      end
      hready = 1'b1;
      step();
      check("t4_m0_issue", obs_haddr, 32'h400);
      check("t4_m0_trans", 32'(obs_htrans), 32'h2);
      step();

      // Reset in the middle of a PEND/DATA sequence, then normal M1 service.
      do_reset();
      set_m(0, T_NONSEQ, 32'h500, 1'b1, 32'h0);
      step();
      set_m(0, T_IDLE, 32'h0, 1'b0, 32'h11111111);
      set_m(1, T_NONSEQ, 32'h600, 1'b0, 32'h0);
      step();
      idle_both();
      hreset = 1'b1;
      step();
      hreset = 1'b0;
      step();
      check("t6_htrans", 32'(obs_htrans), 32'h0);
      check("t6_owner",  32'(obs_owner), 32'h0);
      check("t6_rdy",    32'({obs_m1_rdy, obs_m0_rdy}), 32'h3);
      set_m(1, T_NONSEQ, 32'h700, 1'b0, 32'h0);
      step();
      idle_both();
      step();
      check("t6_m1_issue", obs_haddr, 32'h700);
      step();
      check("t6_m1_owner", 32'(obs_owner), 32'h3);

      // Random traffic, round-robin.
      for (int k = 0; k < 300; k++) begin
         drive_random(60, 75);
         hreset = ($urandom_range(99) == 0);
         step();
      end
      hreset = 1'b0;

      // Fixed priority: M0 must win every contended cycle.
      mode = 1;
      do_reset();
      set_m(0, T_NONSEQ, 32'h0000_0800, 1'b0, 32'h0);
      set_m(1, T_NONSEQ, 32'h1000_0800, 1'b0, 32'h0);
      step();
      step();
      check("t5_first_m0", obs_haddr, 32'h0000_0800);
      for (int k = 0; k < 300; k++) begin
         drive_random(70, 80);
         hreset = ($urandom_range(99) == 0);
         step();
         if (has == 2'b11 && exp_issue) check("t5_m0_priority", 32'(obs_haddr[28]), 32'h0);
      end
      hreset = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
